// File: rtl/mfcc_frame_sink_pkg.sv
// Shared constants for the MFCC frame sink: stream geometry shared with the
// pipeline top, plus the per-slot occupancy encoding.
package mfcc_frame_sink_pkg;

    localparam int unsigned MFCC_DATA_WIDTH = 16;
    localparam int unsigned MFCC_NUM_COEFFS = 4;

    localparam logic SLOT_EMPTY = 1'b0;
    localparam logic SLOT_FULL  = 1'b1;

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mfcc_frame_slot_ram.sv
// Frame buffer storage: NUM_BUFS slots of NUM_COEFFS coefficients, one
// synchronous write port and one asynchronous read port.
module mfcc_frame_slot_ram
    import mfcc_frame_sink_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MFCC_DATA_WIDTH,
    parameter int unsigned NUM_COEFFS = MFCC_NUM_COEFFS,
    parameter int unsigned NUM_BUFS   = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_en_i,
    input  logic [idx_width(NUM_BUFS)-1:0]       wr_slot_i,
    input  logic [idx_width(NUM_COEFFS)-1:0]     wr_idx_i,
    input  logic [DATA_WIDTH-1:0]                wr_data_i,
    input  logic [idx_width(NUM_BUFS)-1:0]       rd_slot_i,
    input  logic [idx_width(NUM_COEFFS)-1:0]     rd_idx_i,
    output logic [DATA_WIDTH-1:0]                rd_data_c_o
);

    logic [DATA_WIDTH-1:0] mem_q [NUM_BUFS][NUM_COEFFS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < int'(NUM_BUFS); b++) begin
                for (int c = 0; c < int'(NUM_COEFFS); c++) begin
                    mem_q[b][c] <= '0;
                end
            end
        end else if (wr_en_i) begin
            mem_q[wr_slot_i][wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_c_o = mem_q[rd_slot_i][rd_idx_i];

endmodule

// File: rtl/mfcc_frame_sink.sv
// MFCC frame sink: assembles NUM_COEFFS-coefficient frames into a slot ring,
// replays them over ready/valid, and drops whole frames when the ring is full.
module mfcc_frame_sink
    import mfcc_frame_sink_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MFCC_DATA_WIDTH,
    parameter int unsigned NUM_COEFFS = MFCC_NUM_COEFFS,
    parameter int unsigned NUM_BUFS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] mfcc_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic [15:0]           frames_done,
    output logic [7:0]            drop_count,
    output logic                  overflow,
    input  logic                  overflow_clr
);

    localparam int unsigned CW = idx_width(NUM_COEFFS);
    localparam int unsigned BW = idx_width(NUM_BUFS);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_COEFFS - 1);

    logic [CW-1:0]       wc_q, wc_d;
    logic [CW-1:0]       rc_q, rc_d;
    logic [BW-1:0]       wp_q, wp_d;
    logic [BW-1:0]       rp_q, rp_d;
    logic [NUM_BUFS-1:0] slot_state_q, slot_state_d;
    logic                dropping_q, dropping_d;
    logic [15:0]         frames_done_q, frames_done_d;
    logic [7:0]          drop_count_q, drop_count_d;
    logic                overflow_q, overflow_d;

    logic rd_valid_c;
    logic rd_fire_c;
    logic wr_en_c;
    logic accept_c;
    logic drop_now_c;

    assign rd_valid_c = (slot_state_q[rp_q] == SLOT_FULL);
    assign rd_fire_c  = rd_valid_c && rd_ready;

    // Read side retires first so a slot freed this cycle is visible to a new frame.
    always_comb begin
        wc_d          = wc_q;
        rc_d          = rc_q;
        wp_d          = wp_q;
        rp_d          = rp_q;
        slot_state_d  = slot_state_q;
        dropping_d    = dropping_q;
        frames_done_d = frames_done_q;
        drop_count_d  = drop_count_q;
        overflow_d    = overflow_q;
        wr_en_c       = 1'b0;
        accept_c      = 1'b0;
        drop_now_c    = 1'b0;

        if (rd_fire_c) begin
            if (rc_q == LAST_IDX) begin
                slot_state_d[rp_q] = SLOT_EMPTY;
                rp_d               = rp_q + BW'(1);
                rc_d               = '0;
            end else begin
                rc_d = rc_q + CW'(1);
            end
        end

        if (valid_in) begin
            wc_d = (wc_q == LAST_IDX) ? '0 : wc_q + CW'(1);
            if (wc_q == '0) begin
                accept_c   = (slot_state_d[wp_q] == SLOT_EMPTY);
                dropping_d = !accept_c;
                drop_now_c = !accept_c;
                if (!accept_c && drop_count_q != 8'hFF) begin
                    drop_count_d = drop_count_q + 8'd1;
                end
            end else begin
                accept_c = !dropping_q;
            end
            if (accept_c) begin
                wr_en_c = 1'b1;
                if (wc_q == LAST_IDX) begin
                    slot_state_d[wp_q] = SLOT_FULL;
                    wp_d               = wp_q + BW'(1);
                    frames_done_d      = frames_done_q + 16'd1;
                end
            end
        end

        if (drop_now_c) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wc_q          <= '0;
            rc_q          <= '0;
            wp_q          <= '0;
            rp_q          <= '0;
            slot_state_q  <= {NUM_BUFS{SLOT_EMPTY}};
            dropping_q    <= 1'b0;
            frames_done_q <= '0;
            drop_count_q  <= '0;
            overflow_q    <= 1'b0;
        end else begin
            wc_q          <= wc_d;
            rc_q          <= rc_d;
            wp_q          <= wp_d;
            rp_q          <= rp_d;
            slot_state_q  <= slot_state_d;
            dropping_q    <= dropping_d;
            frames_done_q <= frames_done_d;
            drop_count_q  <= drop_count_d;
            overflow_q    <= overflow_d;
        end
    end

    mfcc_frame_slot_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_COEFFS (NUM_COEFFS),
        .NUM_BUFS   (NUM_BUFS)
    ) u_slot_ram (
        .clk         (clk),
        .rst         (rst),
        .wr_en_i     (wr_en_c),
        .wr_slot_i   (wp_q),
        .wr_idx_i    (wc_q),
        .wr_data_i   (mfcc_in),
        .rd_slot_i   (rp_q),
        .rd_idx_i    (rc_q),
        .rd_data_c_o (rd_data)
    );

    assign rd_valid    = rd_valid_c;
    assign rd_last     = rd_valid_c && (rc_q == LAST_IDX);
    assign frames_done = frames_done_q;
    assign drop_count  = drop_count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_mfcc_frame_sink.sv
// Bench for mfcc_frame_sink: directed scenarios plus random traffic, checked
// against a frame-level queue model of the sink.
module tb_mfcc_frame_sink;

    localparam int unsigned DW = 16;
    localparam int unsigned NC = 4;
    localparam int unsigned NB = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] mfcc_in;
    logic          valid_in;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic          rd_last;
    logic [15:0]   frames_done;
    logic [7:0]    drop_count;
    logic          overflow;
    logic          overflow_clr;

    mfcc_frame_sink #(.DATA_WIDTH(DW), .NUM_COEFFS(NC), .NUM_BUFS(NB)) dut (
        .clk          (clk),
        .rst          (rst),
        .mfcc_in      (mfcc_in),
        .valid_in     (valid_in),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_last      (rd_last),
        .frames_done  (frames_done),
        .drop_count   (drop_count),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] part_q[$];
    int unsigned   m_wc       = 0;
    bit            m_dropping = 1'b0;
    logic [15:0]   m_frames   = '0;
    logic [7:0]    m_drops    = '0;
    logic          m_ovf      = 1'b0;
    bit            started    = 1'b0;
    bit            post_rst   = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Monitor/model: compare what the DUT shows now, then predict the next edge.
    always @(negedge clk) begin
        bit hs;
        bit drop_now;
        int unsigned held;
        if (started) begin
            check("rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("rd_data", 32'(rd_data), 32'(exp_q[0].data));
                check("rd_last", 32'(rd_last), 32'(exp_q[0].last));
            end else begin
                check("rd_last_idle", 32'(rd_last), 32'(1'b0));
                if (post_rst) check("rd_data_reset", 32'(rd_data), 32'(0));
            end
            check("frames_done", 32'(frames_done), 32'(m_frames));
            check("drop_count", 32'(drop_count), 32'(m_drops));
            check("overflow", 32'(overflow), 32'(m_ovf));
        end
        post_rst = 1'b0;
        if (rst) begin
            exp_q.delete();
            part_q.delete();
            m_wc       = 0;
            m_dropping = 1'b0;
            m_frames   = '0;
            m_drops    = '0;
            m_ovf      = 1'b0;
            started    = 1'b1;
            post_rst   = 1'b1;
        end else if (started) begin
            hs       = (exp_q.size() != 0) && rd_ready;
            drop_now = 1'b0;
            if (hs) void'(exp_q.pop_front());
            if (valid_in) begin
                if (m_wc == 0) begin
                    held = (exp_q.size() + NC - 1) / NC;
                    part_q.delete();
                    if (held < NB) begin
                        m_dropping = 1'b0;
                        part_q.push_back(mfcc_in);
                    end else begin
                        m_dropping = 1'b1;
                        drop_now   = 1'b1;
                        if (m_drops != 8'hFF) m_drops = m_drops + 8'd1;
                    end
                end else if (!m_dropping) begin
                    part_q.push_back(mfcc_in);
                    if (m_wc == NC - 1) begin
                        for (int i = 0; i < int'(NC); i++) begin
                            exp_q.push_back('{data: part_q[i], last: (i == int'(NC) - 1)});
                        end
                        m_frames = m_frames + 16'd1;
                    end
                end
                m_wc = (m_wc + 1) % NC;
            end
            if (drop_now) m_ovf = 1'b1;
            else if (overflow_clr) m_ovf = 1'b0;
        end
    end

    task automatic step(input logic v, input logic [DW-1:0] d, input logic rdy, input logic clr);
        valid_in     = v;
        mfcc_in      = d;
        rd_ready     = rdy;
        overflow_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, rdy, 1'b0);
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input logic rdy, input int gap);
        for (int i = 0; i < int'(NC); i++) begin
            step(1'b1, base + DW'((i + 1) * 16'h0011), rdy, 1'b0);
            for (int g = 0; g < gap; g++) step(1'b0, 16'hDEAD, rdy, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        valid_in = 1'b0;
        mfcc_in = '0;
        rd_ready = 1'b0;
        overflow_clr = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic frame, then backpressure for 5 cycles before draining.
        send_frame(16'h0000, 1'b1, 0);
        idle(6, 1'b1);
        send_frame(16'h0000, 1'b0, 0);
        idle(5, 1'b0);
        idle(6, 1'b1);

        // Overflow: A, B held, C dropped; drain; clear overflow.
        send_frame(16'hA000, 1'b0, 0);
        send_frame(16'hB000, 1'b0, 0);
        send_frame(16'hC000, 1'b0, 0);
        idle(10, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        idle(2, 1'b0);

        // Clear coincident with a drop: set wins.
        send_frame(16'h1000, 1'b0, 0);
        send_frame(16'h2000, 1'b0, 0);
        step(1'b1, 16'h3111, 1'b0, 1'b1);
        for (int i = 1; i < int'(NC); i++) step(1'b1, 16'h3000 + DW'(i), 1'b0, 1'b0);

        // Same-cycle free: last beat of the oldest frame retires as a new frame starts.
        idle(NC - 1, 1'b1);
        send_frame(16'h5000, 1'b1, 0);
        idle(12, 1'b1);

        // Gapped input, one valid beat in three.
        send_frame(16'h6000, 1'b1, 2);
        idle(6, 1'b1);

        // Reset mid-frame with one frame held, then a fresh frame.
        send_frame(16'h7000, 1'b0, 0);
        step(1'b1, 16'h8001, 1'b0, 1'b0);
        step(1'b1, 16'h8002, 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b1, 16'h8003, 1'b0, 1'b0);
        rst = 1'b0;
        idle(1, 1'b0);
        send_frame(16'h9000, 1'b1, 0);
        idle(6, 1'b1);

        // Drop counter saturation.
        send_frame(16'h1100, 1'b0, 0);
        send_frame(16'h2200, 1'b0, 0);
        for (int f = 0; f < 260; f++) send_frame(DW'(f), 1'b0, 0);
        idle(10, 1'b1);
        step(1'b0, 16'h0, 1'b1, 1'b1);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 31) == 0));
        end
        idle(20, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
